cv32e40x_div_seq: RTL and testbench

CV32E40X_DIV_SEQ -- requirements
Module: cv32e40x_div_seq

---
 rtl/cv32e40x_pkg.sv | 48 ++++
 rtl/cv32e40x_div_seq_if.sv | 37 +++
 rtl/cv32e40x_div_seq.sv | 152 +++++++++++++++
 tb/tb_cv32e40x_div_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cv32e40x_pkg.sv
// rtl/cv32e40x_pkg.sv - shared types and helpers for the sequential divider
package cv32e40x_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_opcode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLZ_B  = 3'd1,
    SHIFT  = 3'd2,
    DIVIDE = 3'd3,
    FINISH = 3'd4
  } div_state_e;

  function automatic logic div_is_signed(input div_opcode_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic [DIV_DATA_W-1:0] div_abs(input logic [DIV_DATA_W-1:0] v,
                                                    input logic                  is_signed);
    return (is_signed && v[DIV_DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  // Zero-divisor results bypass sign correction so the raw dividend survives for REM.
  function automatic logic [DIV_DATA_W-1:0] div_result(input div_opcode_e           op,
                                                       input logic [DIV_DATA_W-1:0] quot,
                                                       input logic [DIV_DATA_W-1:0] rem,
                                                       input logic                  sign_a,
                                                       input logic                  sign_b,
                                                       input logic                  b_zero);
    logic [DIV_DATA_W-1:0] res;
    case (op)
      DIV:     res = (!b_zero && (sign_a ^ sign_b)) ? (~quot + 1'b1) : quot;
      DIVU:    res = quot;
      REM:     res = (!b_zero && sign_a) ? (~rem + 1'b1) : rem;
      default: res = rem;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cv32e40x_div_seq_if.sv
// rtl/cv32e40x_div_seq_if.sv - request/result handshake and borrowed ALU CLZ/shifter lines
interface cv32e40x_div_seq_if;
  import cv32e40x_pkg::*;

  logic                  valid_i;
  logic                  ready_o;
  div_opcode_e           operator_i;
  logic [DIV_DATA_W-1:0] op_a_i;
  logic [DIV_DATA_W-1:0] op_b_i;
  logic                  kill_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DIV_DATA_W-1:0] result_o;

  logic                  alu_clz_en_o;
  logic [DIV_DATA_W-1:0] alu_clz_data_o;
  logic [DIV_CNT_W-1:0]  alu_clz_result_i;
  logic                  alu_shift_en_o;
  logic [DIV_CNT_W-1:0]  alu_shift_amt_o;
  logic [DIV_DATA_W-1:0] alu_operand_a_o;
  logic [DIV_DATA_W-1:0] alu_shifted_i;

  modport slave (
    input  valid_i, operator_i, op_a_i, op_b_i, kill_i, ready_i,
           alu_clz_result_i, alu_shifted_i,
    output ready_o, valid_o, result_o,
           alu_clz_en_o, alu_clz_data_o, alu_shift_en_o, alu_shift_amt_o, alu_operand_a_o
  );

  modport master (
    output valid_i, operator_i, op_a_i, op_b_i, kill_i, ready_i,
           alu_clz_result_i, alu_shifted_i,
    input  ready_o, valid_o, result_o,
           alu_clz_en_o, alu_clz_data_o, alu_shift_en_o, alu_shift_amt_o, alu_operand_a_o
  );

endinterface

// File: rtl/cv32e40x_div_seq.sv
// rtl/cv32e40x_div_seq.sv - restoring divider sequencer, CLZ and alignment shift borrowed from the ALU
module cv32e40x_div_seq
  import cv32e40x_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cv32e40x_div_seq_if.slave  bus
);

  div_state_e            state_q, state_d;
  div_opcode_e           op_q, op_d;
  logic                  sign_a_q, sign_a_d;
  logic                  sign_b_q, sign_b_d;
  logic                  b_zero_q, b_zero_d;
  logic [DIV_DATA_W-1:0] b_abs_q, b_abs_d;
  logic [DIV_DATA_W-1:0] rem_q, rem_d;
  logic [DIV_DATA_W-1:0] dvsr_q, dvsr_d;
  logic [DIV_DATA_W-1:0] quot_q, quot_d;
  logic [DIV_DATA_W-1:0] result_q, result_d;
  logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;

  logic                  in_signed;
  logic                  in_b_zero;
  logic                  rem_ge;
  logic [DIV_DATA_W-1:0] rem_diff;

  always_comb begin
    in_signed = div_is_signed(bus.operator_i);
    in_b_zero = (bus.op_b_i == '0);
    rem_ge    = (rem_q >= dvsr_q);
    rem_diff  = rem_q - dvsr_q;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    b_abs_d  = b_abs_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    quot_d   = quot_q;
    result_d = result_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          op_d     = bus.operator_i;
          sign_a_d = in_signed && bus.op_a_i[DIV_DATA_W-1];
          sign_b_d = in_signed && bus.op_b_i[DIV_DATA_W-1];
          b_zero_d = in_b_zero;
          b_abs_d  = div_abs(bus.op_b_i, in_signed);
          cnt_d    = '0;
          dvsr_d   = '0;
          if (in_b_zero) begin
            rem_d   = bus.op_a_i;
            quot_d  = '1;
            state_d = FINISH;
          end else begin
            rem_d   = div_abs(bus.op_a_i, in_signed);
            quot_d  = '0;
            state_d = CLZ_B;
          end
        end
      end
      CLZ_B: begin
        cnt_d   = bus.alu_clz_result_i;
        state_d = SHIFT;
      end
      SHIFT: begin
        dvsr_d  = bus.alu_shifted_i;
        state_d = DIVIDE;
      end
      DIVIDE: begin
        rem_d  = rem_ge ? rem_diff : rem_q;
        quot_d = {quot_q[DIV_DATA_W-2:0], rem_ge};
        dvsr_d = dvsr_q >> 1;
        if (cnt_q == '0) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FINISH: begin
        if (bus.ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.kill_i) begin
      state_d = IDLE;
    end

    // The result is captured on the way into FINISH so it is stable for the whole handshake.
    if ((state_d == FINISH) && (state_q != FINISH)) begin
      result_d = div_result(op_d, quot_d, rem_d, sign_a_d, sign_b_d, b_zero_d);
    end
  end

  always_comb begin
    bus.ready_o         = (state_q == IDLE);
    bus.valid_o         = (state_q == FINISH);
    bus.result_o        = result_q;
    bus.alu_clz_en_o    = 1'b0;
    bus.alu_clz_data_o  = '0;
    bus.alu_shift_en_o  = 1'b0;
    bus.alu_shift_amt_o = '0;
    bus.alu_operand_a_o = '0;
    if (state_q == CLZ_B) begin
      bus.alu_clz_en_o   = 1'b1;
      bus.alu_clz_data_o = b_abs_q;
    end
    if (state_q == SHIFT) begin
      bus.alu_shift_en_o  = 1'b1;
      bus.alu_shift_amt_o = cnt_q;
      bus.alu_operand_a_o = b_abs_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= DIV;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      b_abs_q  <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      quot_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      b_abs_q  <= b_abs_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      quot_q   <= quot_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cv32e40x_div_seq.sv
// tb/tb_cv32e40x_div_seq.sv - directed vector bench for the sequential divider
module tb_cv32e40x_div_seq;
  import cv32e40x_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cv32e40x_div_seq_if bus();

  cv32e40x_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 6'(31 - i);
    end
    return n;
  endfunction

  always_comb begin
    bus.alu_clz_result_i = clz32(bus.alu_clz_data_o);
    bus.alu_shifted_i    = bus.alu_operand_a_o << bus.alu_shift_amt_o[4:0];
  end

  int total = 0;
  int bad   = 0;
  int clz_cnt = 0;

  always @(negedge clk) begin
    if (bus.alu_clz_en_o) clz_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " ready_o"}, 32'(bus.ready_o), 32'd1);
    chk({name, " valid_o"}, 32'(bus.valid_o), 32'd0);
    chk({name, " result_o"}, bus.result_o, 32'd0);
    chk({name, " clz_en"}, 32'(bus.alu_clz_en_o), 32'd0);
    chk({name, " clz_data"}, bus.alu_clz_data_o, 32'd0);
    chk({name, " shift_en"}, 32'(bus.alu_shift_en_o), 32'd0);
    chk({name, " shift_amt"}, 32'(bus.alu_shift_amt_o), 32'd0);
    chk({name, " operand_a"}, bus.alu_operand_a_o, 32'd0);
  endtask

  task automatic do_op(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.operator_i = op;
    bus.op_a_i     = a;
    bus.op_b_i     = b;
    bus.valid_i    = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    lat = 1;
    while (!bus.valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result_o;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall valid_o held", 32'(bus.valid_o), 32'd1);
      chk("stall result stable", bus.result_o, res);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
    chk("release ready_o", 32'(bus.ready_o), 32'd1);
    chk("release valid_o", 32'(bus.valid_o), 32'd0);
  endtask

  typedef struct {
    div_opcode_e op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] res;
    int          lat;
    int          c0;
    int          seen;

    vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vecs[3]  = '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[4]  = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  35};
    vecs[5]  = '{DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[6]  = '{REMU, 32'd5,          32'd0,          32'd5,          1};
    vecs[7]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  35};
    vecs[8]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          35};
    vecs[9]  = '{DIVU, 32'd9,          32'd3,          32'd3,          34};
    vecs[10] = '{DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
    vecs[11] = '{REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34};
    vecs[12] = '{DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1};
    vecs[13] = '{REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
    vecs[14] = '{DIVU, 32'd0,          32'd5,          32'd0,          33};
    vecs[15] = '{REMU, 32'h1234_5678,  32'h0001_0000,  32'h0000_5678,  19};

    rst            = 1'b1;
    bus.valid_i    = 1'b0;
    bus.operator_i = DIVU;
    bus.op_a_i     = '0;
    bus.op_b_i     = '0;
    bus.kill_i     = 1'b0;
    bus.ready_i    = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("in reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("after reset");

    for (int i = 0; i < 16; i++) begin
      c0 = clz_cnt;
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat);
      chk($sformatf("vec%0d result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      if (vecs[i].b == 32'd0) begin
        chk($sformatf("vec%0d clz unused", i), 32'(clz_cnt - c0), 32'd0);
      end
    end

    do_op(DIVU, 32'd1000, 32'd10, 3, res, lat);
    chk("stall result", res, 32'd100);
    chk("stall latency", 32'(lat), 32'd32);

    @(negedge clk);
    bus.operator_i = DIVU;
    bus.op_a_i     = 32'd100;
    bus.op_b_i     = 32'd7;
    bus.valid_i    = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (6) @(negedge clk);
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    chk("kill ready_o", 32'(bus.ready_o), 32'd1);
    chk("kill valid_o", 32'(bus.valid_o), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.valid_o) seen++;
    end
    chk("kill no valid", 32'(seen), 32'd0);
    do_op(DIVU, 32'd9, 32'd3, 0, res, lat);
    chk("after kill result", res, 32'd3);
    chk("after kill latency", 32'(lat), 32'd34);

    @(negedge clk);
    bus.operator_i = DIVU;
    bus.op_a_i     = 32'hFFFF_FFFF;
    bus.op_b_i     = 32'd1;
    bus.valid_i    = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post mid reset");
    do_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, res, lat);
    chk("after reset result", res, 32'hFFFF_FFFD);
    chk("after reset latency", 32'(lat), 32'd34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
